// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding instruction fetch stage.
//   Issues word-aligned requests to instruction memory at the current pc and
//   holds each returned word, with its address and fault flag, in a one-entry
//   output register for decode. pc_enable advances the external PC once per
//   accepted response, and on every flush so that the redirect target is loaded.
//
// Ports:
//   clock            core clock, rising edge
//   reset            asynchronous active-low reset
//   pc               current program counter
//   pc_enable        PC write enable (combinational)
//   flush            redirect from execute; drops in-flight and buffered fetch
//   imem_req_*       request channel (valid/ready/addr); valid is combinational
//   imem_resp_*      response channel (valid/data/error), no back-pressure
//   if_valid/ready   decode handshake
//   if_instruction   fetched word (NOP_INSTRUCTION on faults)
//   if_pc            address of the fetched word
//   if_fault         access or alignment fault
//
// Configuration:
//   FETCH_MISALIGN_TRAP_EN  when defined, a pc with pc[1:0] != 0 issues no
//                           memory request and produces a fault entry instead.

module instruction_fetch #(
    parameter logic [31:0] NOP_INSTRUCTION = 32'h00000013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        pc_enable,
    input  logic        flush,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_error,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    output logic        if_fault
);

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] ST_REQ  = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_DROP = 2'b10;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [XLEN-1:0] req_pc;
    logic            out_space;
    logic            misaligned;
    logic            resp_accept;
    logic            misalign_load;

    // Output register can take a new entry when empty or being drained.
    assign out_space = !if_valid || if_ready;

    assign imem_req_addr = {pc[XLEN-1:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misaligned = (pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and combinational handshake outputs.
    always_comb begin
        state_nxt      = state;
        imem_req_valid = 1'b0;
        resp_accept    = 1'b0;
        misalign_load  = 1'b0;
        pc_enable      = 1'b0;

        case (state)
            ST_REQ: begin
                imem_req_valid = out_space && !flush && !misaligned;
                misalign_load  = out_space && !flush && misaligned;
                // flush suppresses the request, so a handshake never
                // coincides with a flush here.
                if (imem_req_valid && imem_req_ready) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_resp_valid) begin
                    // A response arriving with a flush is simply discarded.
                    resp_accept = !flush;
                    state_nxt   = ST_REQ;
                end else if (flush) begin
                    state_nxt = ST_DROP;
                end
            end
            ST_DROP: begin
                // The response closes the outstanding request even if a
                // further flush arrives with it; otherwise stay here.
                if (imem_resp_valid) begin
                    state_nxt = ST_REQ;
                end
            end
            default: begin
                state_nxt = ST_REQ;
            end
        endcase

        pc_enable = flush || resp_accept;

        // Keep the external handshakes quiet while reset is held.
        if (!reset) begin
            imem_req_valid = 1'b0;
            pc_enable      = 1'b0;
        end
    end

    // Address of the outstanding request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_pc <= '0;
        end else if (imem_req_valid && imem_req_ready) begin
            req_pc <= pc;
        end
    end

    // One-entry output register toward decode.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            if_valid       <= 1'b0;
            if_instruction <= NOP_INSTRUCTION;
            if_pc          <= '0;
            if_fault       <= 1'b0;
        end else begin
            if (flush) begin
                if_valid <= 1'b0;
            end else if (resp_accept) begin
                if_valid       <= 1'b1;
                if_instruction <= imem_resp_error ? NOP_INSTRUCTION : imem_resp_data;
                if_pc          <= req_pc;
                if_fault       <= imem_resp_error;
            end else if (misalign_load) begin
                if_valid       <= 1'b1;
                if_instruction <= NOP_INSTRUCTION;
                if_pc          <= pc;
                if_fault       <= 1'b1;
            end else if (if_valid && if_ready) begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed vector table, hand-written
// corner sequences (reset, flush with response, reset mid-request) and a
// randomized run against a transaction-level reference model.

module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h00000013;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pc_enable;
    logic        flush;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_error;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic        if_fault;

    instruction_fetch #(.NOP_INSTRUCTION(NOP)) dut (
        .clock          (clock),
        .reset          (reset),
        .pc             (pc),
        .pc_enable      (pc_enable),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .imem_resp_error(imem_resp_error),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .if_fault       (if_fault)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic drive(input logic fl, input logic rdy, input logic rv, input logic [31:0] rd,
                         input logic re, input logic ir, input logic [31:0] p);
        flush           = fl;
        imem_req_ready  = rdy;
        imem_resp_valid = rv;
        imem_resp_data  = rd;
        imem_resp_error = re;
        if_ready        = ir;
        pc              = p;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " req_valid"}, imem_req_valid, 0);
        chk({tag, " pc_enable"}, pc_enable, 0);
        chk({tag, " if_valid"}, if_valid, 0);
        chk({tag, " if_instruction"}, if_instruction, NOP);
        chk({tag, " if_pc"}, if_pc, 0);
        chk({tag, " if_fault"}, if_fault, 0);
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic        m_out, m_disc;        // request outstanding / to be discarded
    logic [31:0] m_req_pc;
    logic        e_valid, e_fault;     // buffered entry
    logic [31:0] e_instr, e_pc;
    logic        m_fire, m_pce;

    task automatic model_init();
        m_out = 0; m_disc = 0; m_req_pc = 0;
        e_valid = 0; e_fault = 0; e_instr = NOP; e_pc = 0;
        m_fire = 0; m_pce = 0;
    endtask

    // One clock cycle: drive at negedge, check combinational outputs,
    // advance model over the rising edge, check registered outputs.
    task automatic cyc(input logic fl, input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic re, input logic ir, input logic [31:0] p);
        logic space, mis, xreq, acc;
        drive(fl, rdy, rv, rd, re, ir, p);
        #1;
        space  = !e_valid || ir;
        mis    = TRAP && (p[1:0] != 2'b00);
        xreq   = !m_out && space && !fl && !mis;
        acc    = m_out && !m_disc && rv && !fl;
        m_pce  = fl || acc;
        m_fire = xreq && rdy;
        chk("rnd req_valid", imem_req_valid, xreq);
        if (xreq) chk("rnd req_addr", imem_req_addr, {p[31:2], 2'b00});
        chk("rnd pc_enable", pc_enable, m_pce);
        @(posedge clock);
        if (fl) e_valid = 0;
        else if (acc) begin
            e_valid = 1; e_instr = re ? NOP : rd; e_pc = m_req_pc; e_fault = re;
        end else if (!m_out && mis && space) begin
            e_valid = 1; e_instr = NOP; e_pc = p; e_fault = 1;
        end else if (e_valid && ir) e_valid = 0;
        if (m_out) begin
            if (rv) begin m_out = 0; m_disc = 0; end
            else if (fl) m_disc = 1;
        end else if (m_fire) begin
            m_out = 1; m_disc = 0; m_req_pc = p;
        end
        #1;
        chk("rnd if_valid", if_valid, e_valid);
        if (e_valid) begin
            chk("rnd if_instruction", if_instruction, e_instr);
            chk("rnd if_pc", if_pc, e_pc);
            chk("rnd if_fault", if_fault, e_fault);
        end
        @(negedge clock);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic fl, rdy, rv; logic [31:0] rd; logic re, ir; logic [31:0] p;
        logic xreq; logic [31:0] xaddr; logic xpce;
        logic xval; logic [31:0] xins, xpc; logic xflt;
    } vec_t;

    vec_t tbl [18];

    initial begin
        logic [31:0] cur_pc, tgt, r;
        logic fl, rdy, rv, ir;
        int   pend, pdelay;

        // fl rdy rv rd re ir p | xreq xaddr xpce | xval xins xpc xflt
        tbl[0]  = '{1'b0,1'b1,1'b0,32'h0,1'b0,1'b1,32'h0,   1'b1,32'h0,1'b0, 1'b0,NOP,32'h0,1'b0};
        tbl[1]  = '{1'b0,1'b1,1'b1,32'h00500093,1'b0,1'b1,32'h0, 1'b0,32'h0,1'b1, 1'b1,32'h00500093,32'h0,1'b0};
        tbl[2]  = '{1'b0,1'b1,1'b0,32'h0,1'b0,1'b0,32'h4,   1'b0,32'h0,1'b0, 1'b1,32'h00500093,32'h0,1'b0};
        tbl[3]  = '{1'b0,1'b1,1'b0,32'h0,1'b0,1'b1,32'h4,   1'b1,32'h4,1'b0, 1'b0,NOP,32'h0,1'b0};
        tbl[4]  = '{1'b0,1'b1,1'b1,32'h00A00113,1'b0,1'b0,32'h4, 1'b0,32'h0,1'b1, 1'b1,32'h00A00113,32'h4,1'b0};
        tbl[5]  = '{1'b0,1'b1,1'b0,32'h0,1'b0,1'b0,32'h8,   1'b0,32'h0,1'b0, 1'b1,32'h00A00113,32'h4,1'b0};
        tbl[6]  = '{1'b0,1'b1,1'b0,32'h0,1'b0,1'b0,32'h8,   1'b0,32'h0,1'b0, 1'b1,32'h00A00113,32'h4,1'b0};
        tbl[7]  = '{1'b0,1'b1,1'b0,32'h0,1'b0,1'b1,32'h8,   1'b1,32'h8,1'b0, 1'b0,NOP,32'h0,1'b0};
        tbl[8]  = '{1'b1,1'b1,1'b0,32'h0,1'b0,1'b1,32'h8,   1'b0,32'h0,1'b1, 1'b0,NOP,32'h0,1'b0};
        tbl[9]  = '{1'b0,1'b1,1'b1,32'hDEADBEEF,1'b0,1'b1,32'h100, 1'b0,32'h0,1'b0, 1'b0,NOP,32'h0,1'b0};
        tbl[10] = '{1'b0,1'b1,1'b0,32'h0,1'b0,1'b1,32'h100, 1'b1,32'h100,1'b0, 1'b0,NOP,32'h0,1'b0};
        tbl[11] = '{1'b0,1'b1,1'b1,32'h12345678,1'b0,1'b0,32'h100, 1'b0,32'h0,1'b1, 1'b1,32'h12345678,32'h100,1'b0};
        tbl[12] = '{1'b1,1'b1,1'b0,32'h0,1'b0,1'b0,32'h104, 1'b0,32'h0,1'b1, 1'b0,NOP,32'h0,1'b0};
        tbl[13] = '{1'b0,1'b0,1'b0,32'h0,1'b0,1'b1,32'h10,  1'b1,32'h10,1'b0, 1'b0,NOP,32'h0,1'b0};
        tbl[14] = '{1'b0,1'b1,1'b0,32'h0,1'b0,1'b1,32'h10,  1'b1,32'h10,1'b0, 1'b0,NOP,32'h0,1'b0};
        tbl[15] = '{1'b0,1'b1,1'b1,32'hCAFEF00D,1'b1,1'b0,32'h10, 1'b0,32'h0,1'b1, 1'b1,NOP,32'h10,1'b1};
`ifdef FETCH_MISALIGN_TRAP_EN
        tbl[16] = '{1'b0,1'b1,1'b0,32'h0,1'b0,1'b1,32'h6,   1'b0,32'h0,1'b0, 1'b1,NOP,32'h6,1'b1};
        tbl[17] = '{1'b0,1'b1,1'b1,32'h00000517,1'b0,1'b1,32'h6, 1'b0,32'h0,1'b0, 1'b1,NOP,32'h6,1'b1};
`else
        tbl[16] = '{1'b0,1'b1,1'b0,32'h0,1'b0,1'b1,32'h6,   1'b1,32'h4,1'b0, 1'b0,NOP,32'h0,1'b0};
        tbl[17] = '{1'b0,1'b1,1'b1,32'h00000517,1'b0,1'b1,32'h6, 1'b0,32'h0,1'b1, 1'b1,32'h00000517,32'h6,1'b0};
`endif

        // Reset with noisy inputs: outputs must stay at their reset values.
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h40);
        repeat (3) @(negedge clock);
        #1;
        chk_reset("reset");
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].fl, tbl[i].rdy, tbl[i].rv, tbl[i].rd, tbl[i].re, tbl[i].ir, tbl[i].p);
            #1;
            chk($sformatf("vec%0d req_valid", i), imem_req_valid, tbl[i].xreq);
            if (tbl[i].xreq) chk($sformatf("vec%0d req_addr", i), imem_req_addr, tbl[i].xaddr);
            chk($sformatf("vec%0d pc_enable", i), pc_enable, tbl[i].xpce);
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d if_valid", i), if_valid, tbl[i].xval);
            if (tbl[i].xval) begin
                chk($sformatf("vec%0d if_instruction", i), if_instruction, tbl[i].xins);
                chk($sformatf("vec%0d if_pc", i), if_pc, tbl[i].xpc);
                chk($sformatf("vec%0d if_fault", i), if_fault, tbl[i].xflt);
            end
            @(negedge clock);
        end

        // Flush and response in the same WAIT cycle: response dropped, back to REQ.
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h40);
        #1;
        chk("fr req_valid", imem_req_valid, 1);
        @(negedge clock);
        drive(1'b1, 1'b1, 1'b1, 32'hBAD0BAD0, 1'b0, 1'b1, 32'h40);
        #1;
        chk("fr pc_enable", pc_enable, 1);
        @(posedge clock);
        #1;
        chk("fr if_valid", if_valid, 0);
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h80);
        #1;
        chk("fr next req_valid", imem_req_valid, 1);
        chk("fr next req_addr", imem_req_addr, 32'h80);
        chk("fr next pc_enable", pc_enable, 0);
        @(negedge clock);

        // Reset while waiting for a response; a stale response afterwards is ignored.
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h80);
        #1;
        chk_reset("midreset");
        @(negedge clock);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 32'h11111111, 1'b0, 1'b1, 32'h20);
        #1;
        chk("stale req_valid", imem_req_valid, 1);
        chk("stale req_addr", imem_req_addr, 32'h20);
        chk("stale pc_enable", pc_enable, 0);
        @(posedge clock);
        #1;
        chk("stale if_valid", if_valid, 0);
        @(negedge clock);

        // Randomized run against the reference model; the bench plays PC and memory.
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        model_init();
        cur_pc = 32'h0;
        pend   = 0;
        pdelay = 0;
        for (int n = 0; n < 3000; n++) begin
            r   = $urandom();
            tgt = ($urandom_range(0, 7) == 0) ? r : {r[31:2], 2'b00};
            fl  = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            ir  = ($urandom_range(0, 2) != 0);
            rv  = (pend != 0) ? (pdelay == 0) : ($urandom_range(0, 15) == 0);
            cyc(fl, rdy, rv, $urandom(), ($urandom_range(0, 9) == 0), ir, cur_pc);
            if (pend != 0) begin
                if (pdelay == 0) pend = 0;
                else pdelay--;
            end
            if (m_fire) begin
                pend   = 1;
                pdelay = $urandom_range(0, 2);
            end
            if (m_pce) cur_pc = fl ? tgt : cur_pc + 32'd4;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter NOP_INSTRUCTION, default 32'h00000013, value placed on if_instruction at reset and on fault entries.
REQ-002 clock  input  1  core clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 pc  input  32  current PC from the program counter.
REQ-005 pc_enable  output  1  program-counter write enable (loads externally selected next_pc).
REQ-006 flush  input  1  redirect from execute; discard in-flight and buffered fetch.
REQ-007 imem_req_valid / imem_req_ready / imem_req_addr  output / input / output  1/1/32  instruction-memory request channel.
REQ-008 imem_resp_valid / imem_resp_data / imem_resp_error  input / input / input  1/32/1  instruction-memory response channel (no back-pressure).
REQ-009 if_valid / if_ready  output / input  1/1  decode handshake.
REQ-010 if_instruction / if_pc / if_fault  output / output / output  32/32/1  fetched word, its address, access/alignment fault flag.

Function
REQ-011 FSM states: REQ (issue request), WAIT (await response), DROP (await and discard response); single outstanding request max.
REQ-012 REQ: imem_req_valid=1 iff (!if_valid || if_ready) and flush=0; imem_req_addr={pc[31:2],2'b00}.
REQ-013 REQ: on imem_req_valid && imem_req_ready, latch pc into req_pc, go WAIT.
REQ-014 WAIT: on imem_resp_valid, next cycle output register <= {imem_resp_data, req_pc, imem_resp_error}, if_valid=1; go REQ.
REQ-015 pc_enable = flush | (state==WAIT && imem_resp_valid && !flush); combinational, one cycle per accepted response.
REQ-016 Output register: one entry; cleared (if_valid=0) on if_valid && if_ready unless reloaded same cycle; contents stable while if_valid && !if_ready.
REQ-017 Minimum latency: request handshake cycle N, response N+1, if_valid at N+2; peak throughput one instruction per 2 cycles.
REQ-018 flush: if_valid <= 0 next cycle; WAIT -> DROP; REQ with request handshaking in same cycle -> DROP; REQ otherwise stays REQ.
REQ-019 DROP: on imem_resp_valid discard data, no pc_enable from response, go REQ; flush in DROP keeps DROP.
REQ-020 Flush and response in same WAIT cycle: response discarded, go REQ.
REQ-021 imem_resp_valid in REQ state ignored (stale response after reset).
REQ-022 imem_resp_error=1 produces entry with if_fault=1, if_instruction=NOP_INSTRUCTION, if_pc=req_pc; pc_enable still pulsed.

Reset
REQ-023 While reset=0: state=REQ, if_valid=0, if_instruction=NOP_INSTRUCTION, if_pc=0, if_fault=0, req_pc=0, imem_req_valid=0, pc_enable=0.
REQ-024 Reset mid-WAIT abandons request; first request issued on first rising edge after reset deasserts, addressed by current pc.

Configuration
REQ-025 Macro FETCH_MISALIGN_TRAP_EN.
REQ-026 Defined: in REQ, pc[1:0]!=0 -> no memory request; next cycle entry {NOP_INSTRUCTION, pc, if_fault=1} loaded (subject to REQ-012 space rule), no pc_enable; stays REQ until flush.
REQ-027 Not defined: pc[1:0] ignored, request issued at word-aligned address, no alignment fault generated.

Verification
REQ-028 Reset release, pc=0x0, ready=1, resp 1 cycle later data 0x00500093 -> if_valid, if_instruction=0x00500093, if_pc=0x0, one pc_enable pulse.
REQ-029 if_ready=0 with entry 0x00A00113 held -> entry stable, imem_req_valid=0 until if_ready=1.
REQ-030 Flush during WAIT at pc=0x8, response 0xDEADBEEF next cycle -> discarded, if_valid=0, pc_enable only from flush, next request at new pc=0x100.
REQ-031 imem_resp_error=1 at pc=0x10 -> if_fault=1, if_instruction=0x00000013, if_pc=0x10.
REQ-032 With FETCH_MISALIGN_TRAP_EN, pc=0x6 -> no imem_req_valid, if_fault=1, if_pc=0x6, pc_enable=0; without macro -> request addr 0x4.
